// File: rtl/pred_write_arbiter.sv
// Predicate-register write arbiter: round-robin grant among NREQ requesters,
// plus a 16-cycle clear sequence that zeroes every predicate register.
module pred_write_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ-1:0]      req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 clr_start,
  output logic                 clr_busy,
  output logic                 clr_done,
  output logic                 pw_en,
  output logic [AW-1:0]        pw_addr,
  output logic                 pw_data
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] CLR_LAST = '1;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [AW-1:0] clr_cnt;

  logic [AW-1:0] addr_arr [NREQ];
  logic [PW-1:0] gnt_idx;
  logic          gnt_any;
  logic [PW-1:0] rr_next;

  for (genvar g = 0; g < NREQ; g++) begin : g_addr
    assign addr_arr[g] = req_addr[g*AW +: AW];
  end

  // Round-robin search starting at rr_ptr; suppressed in reset, CLEAR and on clr_start.
  always_comb begin : grant_sel
    logic [PW-1:0] c;
    c         = '0;
    gnt_idx   = '0;
    gnt_any   = 1'b0;
    req_ready = '0;
    if (reset && (state == IDLE) && !clr_start) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        c = PW'((32'(rr_ptr) + k) % NREQ);
        if (!gnt_any && req_valid[c]) begin
          gnt_any = 1'b1;
          gnt_idx = c;
        end
      end
      req_ready[gnt_idx] = gnt_any;
    end
  end

  assign rr_next = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      clr_cnt  <= '0;
      pw_en    <= 1'b0;
      pw_addr  <= '0;
      pw_data  <= 1'b0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      pw_en    <= 1'b0;
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            clr_busy <= 1'b1;
          end else if (gnt_any) begin
            pw_en   <= 1'b1;
            pw_addr <= addr_arr[gnt_idx];
            pw_data <= req_data[gnt_idx];
            rr_ptr  <= rr_next;
          end
        end
        CLEAR: begin
          pw_en   <= 1'b1;
          pw_addr <= clr_cnt;
          pw_data <= 1'b0;
          clr_cnt <= clr_cnt + AW'(1);
          // Last address issued: done pulses alongside its write appearing on pw_*.
          if (clr_cnt == CLR_LAST) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pred_write_arbiter.sv
// Scoreboard bench for pred_write_arbiter: a cycle-level reference model queues
// expected writes; an independent monitor pops and compares them.
module tb_pred_write_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_data;
  logic [NREQ-1:0]    req_ready;
  logic               clr_start;
  logic               clr_busy;
  logic               clr_done;
  logic               pw_en;
  logic [AW-1:0]      pw_addr;
  logic               pw_data;

  pred_write_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .clr_start(clr_start),
    .clr_busy(clr_busy), .clr_done(clr_done), .pw_en(pw_en),
    .pw_addr(pw_addr), .pw_data(pw_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          data;
    logic          done;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model state: who is next in line, and how many clear writes remain.
  int            m_ptr      = 0;
  int            m_clr_left = 0;
  int            m_clr_addr = 0;
  logic [NREQ-1:0] m_granted = '0;
  logic [AW-1:0] last_addr  = '0;
  logic          last_data  = 1'b0;
  bit            mon_en     = 1'b0;

  logic [NREQ-1:0]    r_v = '0;
  logic [NREQ*AW-1:0] r_a = '0;
  logic [NREQ-1:0]    r_d = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // First valid requester at or after the pointer, wrapping; -1 if none.
  function automatic int pick();
    for (int k = 0; k < int'(NREQ); k++) begin
      int i = (m_ptr + k) % int'(NREQ);
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int g;
    m_granted = '0;
    if (!reset) begin
      m_ptr      = 0;
      m_clr_left = 0;
      last_addr  = '0;
      last_data  = 1'b0;
    end else if (m_clr_left > 0) begin
      exp_q.push_back('{addr: AW'(m_clr_addr), data: 1'b0, done: (m_clr_left == 1)});
      last_addr  = AW'(m_clr_addr);
      last_data  = 1'b0;
      m_clr_addr = m_clr_addr + 1;
      m_clr_left = m_clr_left - 1;
    end else if (clr_start) begin
      m_clr_left = 16;
      m_clr_addr = 0;
    end else begin
      g = pick();
      if (g >= 0) begin
        exp_q.push_back('{addr: req_addr[g*AW +: AW], data: req_data[g], done: 1'b0});
        last_addr    = req_addr[g*AW +: AW];
        last_data    = req_data[g];
        m_granted[g] = 1'b1;
        m_ptr        = (g + 1) % int'(NREQ);
      end
    end
  end

  always @(negedge clk) begin : monitor
    wr_t e;
    if (mon_en) begin
      chk("clr_busy", 32'(clr_busy), 32'(m_clr_left > 0));
      if (pw_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("pw_addr", 32'(pw_addr), 32'(e.addr));
          chk("pw_data", 32'(pw_data), 32'(e.data));
          chk("clr_done", 32'(clr_done), 32'(e.done));
        end
      end else begin
        chk("pw_en", 32'(pw_en), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        chk("pw_addr_hold", 32'(pw_addr), 32'(last_addr));
        chk("pw_data_hold", 32'(pw_data), 32'(last_data));
        chk("clr_done_idle", 32'(clr_done), 32'(0));
      end
    end
  end

  task automatic step(input logic rst, input logic clr, input logic [NREQ-1:0] v,
                      input logic [NREQ*AW-1:0] a, input logic [NREQ-1:0] d);
    int g;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    reset     = rst;
    clr_start = clr;
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    #1;
    exp_rdy = '0;
    if (rst && (m_clr_left == 0) && !clr) begin
      g = pick();
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
  endtask

  localparam logic [NREQ*AW-1:0] A_RR   = {4'd11, 4'd7, 4'd3};
  localparam logic [NREQ*AW-1:0] A_PTR  = {4'd0, 4'd5, 4'd0};
  localparam logic [NREQ*AW-1:0] A_SAME = {4'd9, 4'd0, 4'd9};

  initial begin
    reset     = 1'b0;
    clr_start = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    @(posedge clk);
    #1 mon_en = 1'b1;

    // Reset holds everything quiet even with all requesters valid.
    repeat (2) step(1'b0, 1'b0, 3'b111, A_RR, 3'b101);
    // Round-robin rotation 0,1,2,0.
    repeat (4) step(1'b1, 1'b0, 3'b111, A_RR, 3'b101);
    // Pointer follows the last grant.
    step(1'b0, 1'b0, 3'b000, A_PTR, 3'b010);
    step(1'b1, 1'b0, 3'b010, A_PTR, 3'b010);
    repeat (2) step(1'b1, 1'b0, 3'b111, A_PTR, 3'b010);
    // Clear with req0 waiting.
    step(1'b1, 1'b1, 3'b001, A_RR, 3'b101);
    repeat (18) step(1'b1, 1'b0, 3'b001, A_RR, 3'b101);
    // clr_start again at clr_cnt=8 is ignored.
    step(1'b1, 1'b1, 3'b000, A_RR, 3'b000);
    repeat (8) step(1'b1, 1'b0, 3'b000, A_RR, 3'b000);
    step(1'b1, 1'b1, 3'b000, A_RR, 3'b000);
    repeat (10) step(1'b1, 1'b0, 3'b000, A_RR, 3'b000);
    // Reset at clr_cnt=5 aborts with no done pulse.
    step(1'b1, 1'b1, 3'b000, A_RR, 3'b000);
    repeat (5) step(1'b1, 1'b0, 3'b000, A_RR, 3'b000);
    step(1'b0, 1'b0, 3'b000, A_RR, 3'b000);
    repeat (3) step(1'b1, 1'b0, 3'b000, A_RR, 3'b000);
    // Two requesters hitting the same address.
    step(1'b0, 1'b0, 3'b000, A_SAME, 3'b001);
    repeat (3) step(1'b1, 1'b0, 3'b101, A_SAME, 3'b001);

    // Random traffic; requesters hold their request until the model grants it.
    step(1'b0, 1'b0, 3'b000, A_RR, 3'b000);
    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < int'(NREQ); i++) begin
        if (m_granted[i] || !r_v[i]) begin
          r_v[i]             = 1'($urandom_range(0, 1));
          r_a[i*AW +: AW]    = AW'($urandom);
          r_d[i]             = 1'($urandom);
        end
      end
      step(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 29) == 0), r_v, r_a, r_d);
    end

    step(1'b0, 1'b0, 3'b000, A_RR, 3'b000);
    repeat (3) step(1'b1, 1'b0, 3'b000, A_RR, 3'b000);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
